// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The memory returns the words at imem_addr and imem_addr+4 together.
interface instruction_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata0;
    logic [31:0] imem_rdata1;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata0, imem_rdata1
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata0, imem_rdata1
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Dual-issue fetch stage: keeps the fetch PC, requests two-word bundles from
// instruction memory and fills the IF/ID register, handling stalls and redirects.
package instruction_fetch_stage_pkg;
    localparam int unsigned INSTR_ID_W = 8;

    typedef enum logic [3:0] {
        EXCEPTION_NONE             = 4'd0,
        EXCEPTION_ADDR_ERROR_FETCH = 4'd4
    } exception_t;

    typedef struct packed {
        logic                  valid0;
        logic [31:0]           pc0;
        logic [31:0]           instruction0;
        logic [INSTR_ID_W-1:0] instr_id0;
        exception_t            exception0;
        logic                  valid1;
        logic [31:0]           pc1;
        logic [31:0]           instruction1;
        logic [INSTR_ID_W-1:0] instr_id1;
        exception_t            exception1;
    } IF_ID_Register;
endpackage

module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        issue_one,
    input  logic                        jump_enable,
    input  logic [31:0]                 jump_addr,
    instruction_fetch_stage_if.master   imem,
    output IF_ID_Register               if_id_reg
);

    logic [31:0]           fetch_pc;
    logic [31:0]           req_pc;
    logic [INSTR_ID_W-1:0] next_id;
    logic                  outstanding;
    logic                  drop;
    logic                  halted;
    logic                  buf_valid;
    logic [31:0]           buf_pc;
    logic [31:0]           buf_data0;
    logic [31:0]           buf_data1;

    logic                  direct_take;
    logic                  redirect;
    logic                  accept;
    logic                  outstanding_next;
    logic                  misaligned_fetch;
    logic [1:0]            id_step;
    logic                  set_halt;
    IF_ID_Register         if_id_next;

    function automatic IF_ID_Register make_bundle(input logic [31:0] pc,
                                                  input logic [31:0] d0,
                                                  input logic [31:0] d1,
                                                  input logic [INSTR_ID_W-1:0] id);
        IF_ID_Register b;
        b              = '0;
        b.valid0       = 1'b1;
        b.pc0          = pc;
        b.instruction0 = d0;
        b.instr_id0    = id;
        b.exception0   = EXCEPTION_NONE;
        b.valid1       = 1'b1;
        b.pc1          = pc + 32'd4;
        b.instruction1 = d1;
        b.instr_id1    = id + INSTR_ID_W'(1);
        b.exception1   = EXCEPTION_NONE;
        return b;
    endfunction

    assign imem.imem_req  = !rst && !halted && (fetch_pc[1:0] == 2'b00) && !buf_valid &&
                            (!outstanding || (imem.imem_rvalid && direct_take));
    assign imem.imem_addr = fetch_pc;

    always_comb begin
        direct_take      = !stall && !issue_one && !jump_enable && !drop;
        redirect         = jump_enable && !stall;
        accept           = imem.imem_req && imem.imem_ready;
        outstanding_next = accept || (outstanding && !imem.imem_rvalid);
        misaligned_fetch = !halted && (fetch_pc[1:0] != 2'b00) && !outstanding && !buf_valid;
    end

    always_comb begin
        if_id_next = if_id_reg;
        id_step    = 2'd0;
        set_halt   = 1'b0;
        if (stall) begin
            if_id_next = if_id_reg;
        end else if (jump_enable) begin
            if_id_next = '0;
        end else if (issue_one) begin
            if_id_next              = '0;
            if_id_next.valid0       = if_id_reg.valid1;
            if_id_next.pc0          = if_id_reg.pc1;
            if_id_next.instruction0 = if_id_reg.instruction1;
            if_id_next.instr_id0    = if_id_reg.instr_id1;
            if_id_next.exception0   = if_id_reg.exception1;
        end else if (buf_valid) begin
            if_id_next = make_bundle(buf_pc, buf_data0, buf_data1, next_id);
            id_step    = 2'd2;
        end else if (imem.imem_rvalid && !drop) begin
            if_id_next = make_bundle(req_pc, imem.imem_rdata0, imem.imem_rdata1, next_id);
            id_step    = 2'd2;
        end else if (misaligned_fetch) begin
            if_id_next            = '0;
            if_id_next.valid0     = 1'b1;
            if_id_next.pc0        = fetch_pc;
            if_id_next.instr_id0  = next_id;
            if_id_next.exception0 = EXCEPTION_ADDR_ERROR_FETCH;
            id_step               = 2'd1;
            set_halt              = 1'b1;
        end else begin
            if_id_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_reg   <= '0;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            next_id     <= '0;
            halted      <= 1'b0;
            buf_valid   <= 1'b0;
            buf_pc      <= '0;
            buf_data0   <= '0;
            buf_data1   <= '0;
            // A request in flight at reset still returns; remember to discard it.
            outstanding <= outstanding && !imem.imem_rvalid;
            drop        <= outstanding && !imem.imem_rvalid;
        end else begin
            if_id_reg   <= if_id_next;
            next_id     <= next_id + INSTR_ID_W'(id_step);
            outstanding <= outstanding_next;
            if (set_halt)
                halted <= 1'b1;
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd8;
                req_pc   <= fetch_pc;
            end
            if (imem.imem_rvalid && drop)
                drop <= 1'b0;

            if (redirect) begin
                buf_valid <= 1'b0;
            end else if (!stall && !issue_one && buf_valid) begin
                buf_valid <= 1'b0;
            end else if (imem.imem_rvalid && !drop && !direct_take) begin
                buf_valid <= 1'b1;
                buf_pc    <= req_pc;
                buf_data0 <= imem.imem_rdata0;
                buf_data1 <= imem.imem_rdata1;
            end

            // Drop keys off the post-edge in-flight state so a request accepted
            // in the redirect cycle itself is also discarded.
            if (redirect) begin
                fetch_pc <= jump_addr;
                halted   <= 1'b0;
                drop     <= outstanding_next;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a randomized run
// checked against an instruction-stream model of what decode should consume.
module tb_instruction_fetch_stage;
    import instruction_fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          issue_one;
    logic          jump_enable;
    logic [31:0]   jump_addr;
    IF_ID_Register if_id_reg;

    instruction_fetch_stage_if imem_bus ();

    instruction_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .issue_one   (issue_one),
        .jump_enable (jump_enable),
        .jump_addr   (jump_addr),
        .imem        (imem_bus),
        .if_id_reg   (if_id_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        mq[$];
    int unsigned cyc;
    int unsigned lat;
    bit          rand_lat;
    int unsigned ready_pct;
    bit          req_s;
    logic [31:0] addr_s;
    int          checks;
    int          errors;

    bit                    track;
    logic [31:0]           exp_pc;
    logic [INSTR_ID_W-1:0] exp_id;
    bit                    m_halted;
    int unsigned           consumed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic IF_ID_Register bundle(input logic [31:0] pc, input logic [INSTR_ID_W-1:0] id);
        IF_ID_Register b;
        b              = '0;
        b.valid0       = 1'b1;
        b.pc0          = pc;
        b.instruction0 = mem_word(pc);
        b.instr_id0    = id;
        b.exception0   = EXCEPTION_NONE;
        b.valid1       = 1'b1;
        b.pc1          = pc + 32'd4;
        b.instruction1 = mem_word(pc + 32'd4);
        b.instr_id1    = id + INSTR_ID_W'(1);
        b.exception1   = EXCEPTION_NONE;
        return b;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input IF_ID_Register obs, input IF_ID_Register exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic consume_slot(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [INSTR_ID_W-1:0] id, input exception_t ex);
        check32("stream_pc", pc, exp_pc);
        check32("stream_id", 32'(id), 32'(exp_id));
        if (exp_pc[1:0] != 2'b00) begin
            check32("stream_exc", 32'(ex), 32'(EXCEPTION_ADDR_ERROR_FETCH));
            check32("stream_instr", instr, 32'd0);
            m_halted = 1'b1;
        end else begin
            check32("stream_exc", 32'(ex), 32'(EXCEPTION_NONE));
            check32("stream_instr", instr, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        exp_id = exp_id + INSTR_ID_W'(1);
        consumed++;
    endtask

    // Decode consumes slot 0 (and slot 1 unless issue_one) whenever it is not stalled.
    task automatic observe();
        if (stall)
            return;
        if (m_halted) begin
            check32("halt_empty", 32'(if_id_reg.valid0), 32'd0);
        end else begin
            if (if_id_reg.valid0)
                consume_slot(if_id_reg.pc0, if_id_reg.instruction0, if_id_reg.instr_id0, if_id_reg.exception0);
            if ((jump_enable || !issue_one) && if_id_reg.valid1 && !m_halted)
                consume_slot(if_id_reg.pc1, if_id_reg.instruction1, if_id_reg.instr_id1, if_id_reg.exception1);
        end
        if (jump_enable) begin
            exp_pc   = jump_addr;
            m_halted = 1'b0;
        end
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic tick();
        int unsigned l;
        imem_bus.imem_ready = ($urandom_range(99) < ready_pct);
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata0 = mem_word(mq[0].addr);
            imem_bus.imem_rdata1 = mem_word(mq[0].addr + 32'd4);
        end else begin
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata0 = '0;
            imem_bus.imem_rdata1 = '0;
        end
        #1;
        req_s  = imem_bus.imem_req;
        addr_s = imem_bus.imem_addr;
        if (track && !rst)
            observe();
        @(posedge clk);
        if (imem_bus.imem_rvalid)
            void'(mq.pop_front());
        if (req_s && imem_bus.imem_ready) begin
            l = rand_lat ? $urandom_range(3, 1) : lat;
            mq.push_back('{addr_s, cyc + l});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int unsigned max);
        int unsigned n;
        n = 0;
        while (!if_id_reg.valid0 && n < max) begin
            tick();
            n++;
        end
        check32(tag, 32'(if_id_reg.valid0), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int unsigned max);
        int unsigned n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!req_s && n < max);
        check32(tag, 32'(req_s), 32'd1);
    endtask

    initial begin
        IF_ID_Register e;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        lat       = 1;
        rand_lat  = 1'b0;
        ready_pct = 100;
        track     = 1'b0;
        consumed  = 0;
        m_halted  = 1'b0;
        exp_pc    = RESET_PC;
        exp_id    = '0;
        rst = 1'b1; stall = 1'b0; issue_one = 1'b0; jump_enable = 1'b0; jump_addr = '0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata0 = '0; imem_bus.imem_rdata1 = '0;
        @(negedge clk);

        // Reset values, then back-to-back bundles with 1-cycle memory
        tick(); tick();
        check_ifid("rst_if_id", if_id_reg, '0);
        check32("rst_req", 32'(req_s), 32'd0);
        check32("rst_addr", imem_bus.imem_addr, RESET_PC);
        rst = 1'b0;
        tick();
        check32("first_req", 32'(req_s), 32'd1);
        check32("first_addr", addr_s, RESET_PC);
        tick();
        check_ifid("bundle0", if_id_reg, bundle(RESET_PC, 8'd0));
        tick();
        check_ifid("bundle1", if_id_reg, bundle(RESET_PC + 32'd8, 8'd2));

        // Stall across an arriving response
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_ifid("stall_hold", if_id_reg, bundle(RESET_PC + 32'd8, 8'd2));
            check32("stall_req", 32'(req_s), 32'd0);
        end
        stall = 1'b0;
        tick();
        check_ifid("stall_buffered", if_id_reg, bundle(RESET_PC + 32'd16, 8'd4));
        tick();
        wait_valid("stall_next_valid", 6);
        check_ifid("stall_next", if_id_reg, bundle(RESET_PC + 32'd24, 8'd6));

        // Partial issue: reach 0x100 with ids 4/5 via an early redirect
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; jump_enable = 1'b1; jump_addr = 32'h0000_00F0;
        tick();
        jump_enable = 1'b0;
        check_ifid("early_jump_bubble", if_id_reg, '0);
        wait_valid("f0_valid", 8);
        check_ifid("f0_bundle", if_id_reg, bundle(32'h0F0, 8'd0));
        tick();
        check_ifid("f8_bundle", if_id_reg, bundle(32'h0F8, 8'd2));
        tick();
        check_ifid("b100_bundle", if_id_reg, bundle(32'h100, 8'd4));
        issue_one = 1'b1;
        tick();
        issue_one = 1'b0;
        e              = '0;
        e.valid0       = 1'b1;
        e.pc0          = 32'h104;
        e.instruction0 = mem_word(32'h104);
        e.instr_id0    = 8'd5;
        check_ifid("issue_one_shift", if_id_reg, e);
        tick();
        check_ifid("after_issue_one", if_id_reg, bundle(32'h108, 8'd6));

        // Redirect with a 3-cycle request in flight
        lat = 3;
        wait_req("slow_req_seen", 5);
        jump_enable = 1'b1; jump_addr = 32'h200;
        tick();
        jump_enable = 1'b0;
        check_ifid("jump_bubble", if_id_reg, '0);
        wait_valid("j200_valid", 12);
        check_ifid("j200_bundle", if_id_reg, bundle(32'h200, 8'd8));

        // Misaligned redirect target
        lat = 1;
        jump_enable = 1'b1; jump_addr = 32'h202;
        tick();
        jump_enable = 1'b0;
        wait_valid("misalign_valid", 10);
        e            = '0;
        e.valid0     = 1'b1;
        e.pc0        = 32'h202;
        e.instr_id0  = 8'd10;
        e.exception0 = EXCEPTION_ADDR_ERROR_FETCH;
        check_ifid("misalign_bundle", if_id_reg, e);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check32("halted_req", 32'(req_s), 32'd0);
        end
        jump_enable = 1'b1; jump_addr = 32'h300;
        tick();
        jump_enable = 1'b0;
        wait_valid("j300_valid", 8);
        check_ifid("j300_bundle", if_id_reg, bundle(32'h300, 8'd11));

        // Reset while a slow request is outstanding
        lat = 3;
        wait_req("pre_rst_req", 5);
        rst = 1'b1;
        tick();
        check_ifid("midrst_if_id", if_id_reg, '0);
        check32("midrst_addr", imem_bus.imem_addr, RESET_PC);
        rst = 1'b0;
        lat = 1;
        wait_valid("post_rst_valid", 12);
        check_ifid("post_rst_bundle", if_id_reg, bundle(RESET_PC, 8'd0));

        // Randomized run against the instruction-stream model
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        rand_lat  = 1'b1;
        ready_pct = 80;
        exp_pc    = RESET_PC;
        exp_id    = '0;
        m_halted  = 1'b0;
        track     = 1'b1;
        for (int unsigned i = 0; i < 3000; i++) begin
            stall       = ($urandom_range(99) < 20);
            issue_one   = !stall && ($urandom_range(99) < 15);
            jump_enable = ($urandom_range(99) < (m_halted ? 25 : 4));
            jump_addr   = 32'h0000_1000 + 32'($urandom_range(511)) * 32'd4;
            if ($urandom_range(99) < 10)
                jump_addr = jump_addr | 32'($urandom_range(3, 1));
            tick();
        end
        stall = 1'b0; issue_one = 1'b0; jump_enable = 1'b0;
        track = 1'b0;
        check32("stream_progress", 32'(consumed >= 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
